schmidl_cox_preamble_inserter: RTL
==================================

// Module: schmidl_cox_preamble_inserter
// PURPOSE
//  Transmit-side counterpart of the Schmidl-Cox synchroniser. Prepends one training symbol to every input frame.
//  The training symbol is a cyclic prefix followed by two identical halves of HALF_FFT_SIZE samples each.
//  The receiver's P(d)/R(d) metric peaks on this symbol.
//  Sits in the TX chain after the IFFT/CP-insertion stage, before the radio; frames delimited by i_tlast.
// PARAMETERS
//  FFT_SIZE  1024  OFDM symbol length; power of 2, >=8; HALF_FFT_SIZE = FFT_SIZE/2
//  CP_SIZE   128   preamble cyclic prefix length; 1..HALF_FFT_SIZE
// PORTS
//  clk          in   1   single clock for all logic
//  aresetn      in   1   reset, asynchronous assert, active-low
//  clear        in   1   synchronous clear: FSM to IDLE, counters 0, output register emptied; RAM kept
//  enable       in   1   1=insert preamble, 0=pure pass-through; sampled only in IDLE
//  pre_wr_en    in   1   preamble RAM write strobe
//  pre_wr_addr  in   $clog2(HALF_FFT_SIZE)  half-symbol sample index
//  pre_wr_data  in   32  sample {I[31:16],Q[15:0]}, sc16
//  pre_wr_ready out  1   1 only in IDLE; writes with pre_wr_ready=0 are dropped
//  i_tdata/i_tlast/i_tvalid/i_tready   AXIS in, 32-bit sc16 frame samples
//  o_tdata/o_tlast/o_tvalid/o_tready   AXIS out, 32-bit sc16
//  o_sof        out  1   qualifies o_tdata: first sample of a burst (first CP sample, or first data sample if enable=0)
// BEHAVIOUR
//  Reset/clear state: o_tvalid=0, o_tlast=0, o_sof=0, o_tdata=0, i_tready=0, pre_wr_ready=1, FSM=IDLE.
//  FSM: IDLE -> PRE_CP -> PRE_H0 -> PRE_H1 -> DATA -> IDLE.
//  - IDLE: i_tready=0. On i_tvalid=1: go to PRE_CP if enable=1, else go to DATA. Input word is not consumed.
//  - PRE_CP: emits CP_SIZE samples, RAM addresses HALF_FFT_SIZE-CP_SIZE .. HALF_FFT_SIZE-1. i_tready=0.
//  - PRE_H0 and PRE_H1: each emits RAM addresses 0..HALF_FFT_SIZE-1. i_tready=0.
//  - DATA: i_tdata forwarded unmodified. i_tready = output register empty or o_tready.
//    Leaves to IDLE on acceptance of the word with i_tlast=1.
//  Sample counter: advances on output-register load only. Wraps 0 at each state change.
//  Output timing:
//  - Output is a single register stage; 1-cycle latency in DATA.
//  - RAM read is synchronous (1 cycle) and prefetched. With o_tready held 1, the CP_SIZE+FFT_SIZE preamble
//    samples and the data follow back-to-back with no bubbles.
//  - Successive frames: next preamble starts the cycle after the tlast word leaves DATA; one IDLE cycle is allowed.
//  o_tlast=1 only on the last data sample of a frame; never inside the preamble.
//  AXIS rules: o_tdata/o_tlast/o_sof held stable while o_tvalid=1 and o_tready=0. o_tvalid is never withdrawn without a handshake.
//  Single-sample frame (i_tlast on first word): full preamble, then that word with o_tlast=1.
//  RAM write and read in the same cycle cannot occur (writes only in IDLE). RAM contents survive clear; undefined after power-up until written.
//  aresetn mid-burst: output drops immediately (o_tvalid=0). The partial burst is abandoned. The next frame gets a full preamble.
//  clear mid-burst: same, on next clk edge.
// STRUCTURE
//  Package schmidl_cox_pkg:
//  - state enum sc_tx_state_t {IDLE,PRE_CP,PRE_H0,PRE_H1,DATA}
//  - typedef sc16_t (32-bit packed I/Q)
//  - function half_fft(FFT_SIZE)
//  Sub-module preamble_ram: HALF_FFT_SIZE x 32 simple dual-port, sync read, 1-cycle latency.
//  Top level keeps FSM, counter, prefetch and output register.
// TESTING (FFT_SIZE=16, CP_SIZE=4, HALF=8; RAM[k]={16'(k),16'(k)}, o_tready=1 unless noted)
//  1 Frame of 5 words 0xA0..0xA4 -> 25 output words:
//    RAM 4,5,6,7, 0..7, 0..7, then A0..A4. o_sof on word 0, o_tlast on A4 only. No bubbles.
//  2 Two back-to-back 3-word frames -> 23+23 words. Second o_sof within 1 cycle of first o_tlast.
//  3 o_tready random 50% -> same sequence as test 1. o_tdata stable whenever o_tvalid&!o_tready. No sample lost or duplicated.
//  4 enable=0, frame of 3 words -> exactly 3 output words. o_sof on first, o_tlast on third.
//    enable toggled mid-frame -> no effect until IDLE.
//  5 aresetn=0 during PRE_H0 at count 3 -> o_tvalid=0 immediately.
//    After release, a 2-word frame yields 4+16+2 words with full preamble.
//    Repeat with clear -> same; RAM contents unchanged.
//  6 pre_wr_en pulse during PRE_H1 (pre_wr_ready=0) -> RAM unchanged, the next preamble is identical to the previous one.
//    Single-word frame -> 21 words, tlast on 21st.

Source files
------------

// File: rtl/schmidl_cox_pkg.sv
// Shared types and helpers for the Schmidl-Cox preamble inserter.
package schmidl_cox_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRE_CP,
    PRE_H0,
    PRE_H1,
    DATA
  } sc_tx_state_t;

  // {I[31:16], Q[15:0]}, both signed 16-bit
  typedef logic [31:0] sc16_t;

  function automatic int unsigned half_fft(input int unsigned fft_size);
    return fft_size / 2;
  endfunction

endpackage

// File: rtl/preamble_ram.sv
// Half-symbol training sample store: one write port, one synchronous read port.
module preamble_ram #(
  parameter int unsigned DEPTH = 512,
  parameter int unsigned AW    = 9
) (
  input  logic          clk,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [31:0]   i_wr_data,
  input  logic [AW-1:0] i_rd_addr,
  output logic [31:0]   o_rd_data
);

  logic [31:0] r_mem [DEPTH];
  logic [31:0] r_rd_data;

  // Write-first bypass so a same-cycle write/read of one address returns the new sample
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
    if (i_wr_en && (i_wr_addr == i_rd_addr)) begin
      r_rd_data <= i_wr_data;
    end else begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/schmidl_cox_preamble_inserter.sv
// Prepends a CP + two identical half-symbol training symbol to each AXIS frame.
module schmidl_cox_preamble_inserter
  import schmidl_cox_pkg::*;
#(
  parameter int unsigned FFT_SIZE = 1024,
  parameter int unsigned CP_SIZE  = 128
) (
  input  logic                                   clk,
  input  logic                                   aresetn,
  input  logic                                   clear,
  input  logic                                   enable,
  input  logic                                   pre_wr_en,
  input  logic [$clog2(half_fft(FFT_SIZE))-1:0]  pre_wr_addr,
  input  logic [31:0]                            pre_wr_data,
  output logic                                   pre_wr_ready,
  input  logic [31:0]                            i_tdata,
  input  logic                                   i_tlast,
  input  logic                                   i_tvalid,
  output logic                                   i_tready,
  output logic [31:0]                            o_tdata,
  output logic                                   o_tlast,
  output logic                                   o_tvalid,
  input  logic                                   o_tready,
  output logic                                   o_sof
);

  localparam int unsigned HALF = half_fft(FFT_SIZE);
  localparam int unsigned AW   = $clog2(HALF);

  sc_tx_state_t  r_state, w_state_next;
  logic [AW-1:0] r_cnt, w_cnt_next;
  logic          r_byp_sof;
  logic          r_valid, r_last, r_sof;
  sc16_t         r_data;

  logic          w_out_free, w_load;
  logic          w_src_valid, w_src_last, w_src_sof;
  sc16_t         w_src_data, w_ram_rd_data;
  logic [AW-1:0] w_rd_addr;
  logic          w_wr_en;

  assign w_out_free = !r_valid || o_tready;
  assign w_load     = w_src_valid && w_out_free;
  assign w_wr_en    = pre_wr_en && pre_wr_ready;

  // Prefetch: address the sample that will be current next cycle, so RAM output is always live
  assign w_rd_addr = (w_state_next == PRE_CP) ? (AW'(HALF - CP_SIZE) + w_cnt_next) : w_cnt_next;

  preamble_ram #(
    .DEPTH(HALF),
    .AW   (AW)
  ) u_ram (
    .clk      (clk),
    .i_wr_en  (w_wr_en),
    .i_wr_addr(pre_wr_addr),
    .i_wr_data(pre_wr_data),
    .i_rd_addr(w_rd_addr),
    .o_rd_data(w_ram_rd_data)
  );

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_byp_sof <= 1'b0;
    end else if (clear) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_byp_sof <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      if ((r_state == IDLE) && i_tvalid && !enable) begin
        r_byp_sof <= 1'b1;
      end else if (w_load) begin
        r_byp_sof <= 1'b0;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      IDLE: begin
        if (i_tvalid) begin
          w_state_next = enable ? PRE_CP : DATA;
          w_cnt_next   = '0;
        end
      end
      PRE_CP: begin
        if (w_load) begin
          if (r_cnt == AW'(CP_SIZE - 1)) begin
            w_state_next = PRE_H0;
            w_cnt_next   = '0;
          end else begin
            w_cnt_next = r_cnt + 1'b1;
          end
        end
      end
      PRE_H0, PRE_H1: begin
        if (w_load) begin
          if (r_cnt == AW'(HALF - 1)) begin
            w_state_next = (r_state == PRE_H0) ? PRE_H1 : DATA;
            w_cnt_next   = '0;
          end else begin
            w_cnt_next = r_cnt + 1'b1;
          end
        end
      end
      DATA: begin
        if (w_load) begin
          if (i_tlast) begin
            w_state_next = IDLE;
            w_cnt_next   = '0;
          end else begin
            w_cnt_next = r_cnt + 1'b1;
          end
        end
      end
      default: begin
        w_state_next = IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  always_comb begin
    w_src_valid  = 1'b0;
    w_src_data   = w_ram_rd_data;
    w_src_last   = 1'b0;
    w_src_sof    = 1'b0;
    i_tready     = 1'b0;
    pre_wr_ready = (r_state == IDLE);
    case (r_state)
      PRE_CP: begin
        w_src_valid = 1'b1;
        w_src_sof   = (r_cnt == '0);
      end
      PRE_H0, PRE_H1: begin
        w_src_valid = 1'b1;
      end
      DATA: begin
        w_src_valid = i_tvalid;
        w_src_data  = i_tdata;
        w_src_last  = i_tlast;
        w_src_sof   = r_byp_sof;
        i_tready    = w_out_free;
      end
      default: begin
        w_src_valid = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_last  <= 1'b0;
      r_sof   <= 1'b0;
    end else if (clear) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_last  <= 1'b0;
      r_sof   <= 1'b0;
    end else if (w_load) begin
      r_valid <= 1'b1;
      r_data  <= w_src_data;
      r_last  <= w_src_last;
      r_sof   <= w_src_sof;
    end else if (o_tready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_tvalid = r_valid;
  assign o_tdata  = r_data;
  assign o_tlast  = r_last;
  assign o_sof    = r_sof;

endmodule
